// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit.
// One access at a time through a three-state handshake (IDLE -> REQ -> DONE).
// Stores are steered onto byte lanes with a byte mask. Loads are formatted on
// the returning word. A request that waits MEM_TIMEOUT cycles for an ack is
// abandoned and reported as a bus error.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word accesses are trapped. When it is undefined, the offending low
// address bits are ignored.
module mem_stage_lsu #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_validM,
  input  logic        i_mem_renM,
  input  logic        i_mem_wenM,
  input  logic        i_flushM,
  input  logic [2:0]  i_funct3M,
  input  logic [31:0] i_addrM,
  input  logic [31:0] i_wdataM,
  output logic [31:0] o_ld_dataM,
  output logic        o_stallM,
  output logic        o_misalignM,
  output logic        o_bus_errM,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic        access_s, issue_s, misalign_s, ack_done_s, timeout_s;
  logic [31:0] addr_r, wdata_r, ld_data_r;
  logic [3:0]  bmask_r;
  logic        we_r, bus_err_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [CW-1:0] cnt_r;

  // Byte-lane mask for an access: byte/halfword stores pick lanes, everything else uses the full word.
  function automatic logic [3:0] fmt_store_mask(input logic st, input logic [2:0] f3,
                                                input logic [1:0] off);
    logic [3:0] m;
    if (!st) begin
      m = 4'b1111;
    end else begin
      case (f3)
        3'b000:  m = 4'b0001 << off;
        3'b001:  m = off[1] ? 4'b1100 : 4'b0011;
        default: m = 4'b1111;
      endcase
    end
    return m;
  endfunction

  // Store data replicated across lanes so the mask alone selects the target bytes.
  function automatic logic [31:0] fmt_store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Extract and extend the addressed byte/halfword from the returned word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign access_s = i_validM & (i_mem_renM | i_mem_wenM) & ~i_flushM;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_r;

  // Classify the incoming access as misaligned (halfword on odd byte, word off a word boundary).
  always_comb begin
    misalign_s = 1'b0;
    if (i_funct3M[1:0] == 2'b01) begin
      misalign_s = i_addrM[0];
    end else if (i_funct3M[1]) begin
      misalign_s = (i_addrM[1:0] != 2'b00);
    end else begin
      misalign_s = 1'b0;
    end
  end

  // One-cycle trap pulse for a misaligned access seen while idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= (state_r == ST_IDLE) & access_s & misalign_s;
    end
  end

  assign o_misalignM = misalign_r;
`else
  assign misalign_s  = 1'b0;
  assign o_misalignM = 1'b0;
`endif

  assign issue_s = (state_r == ST_IDLE) & access_s & ~misalign_s;

  // Next-state logic; ack takes priority over the timeout limit in the same cycle.
  always_comb begin
    state_nx_s = state_r;
    ack_done_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) state_nx_s = ST_REQ;
        else         state_nx_s = ST_IDLE;
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          ack_done_s = 1'b1;
          state_nx_s = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s  = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, latched request, timeout counter, load result and bus-error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      bmask_r   <= 4'd0;
      we_r      <= 1'b0;
      f3_r      <= 3'd0;
      off_r     <= 2'd0;
      cnt_r     <= '0;
      ld_data_r <= 32'd0;
      bus_err_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      bus_err_r <= timeout_s;
      if (issue_s) begin
        addr_r  <= {i_addrM[31:2], 2'b00};
        wdata_r <= fmt_store_data(i_funct3M, i_wdataM);
        bmask_r <= fmt_store_mask(i_mem_wenM, i_funct3M, i_addrM[1:0]);
        we_r    <= i_mem_wenM;
        f3_r    <= i_funct3M;
        off_r   <= i_addrM[1:0];
        cnt_r   <= '0;
      end else if (state_r == ST_REQ) begin
        cnt_r   <= cnt_r + CW'(1);
      end else begin
        cnt_r   <= cnt_r;
      end
      if (ack_done_s && !we_r) begin
        ld_data_r <= fmt_load(f3_r, off_r, i_mem_rdata);
      end else begin
        ld_data_r <= ld_data_r;
      end
    end
  end

  assign o_stallM    = issue_s | (state_r == ST_REQ);
  assign o_mem_req   = (state_r == ST_REQ);
  assign o_mem_we    = (state_r == ST_REQ) & we_r;
  assign o_mem_bmask = (state_r == ST_REQ) ? bmask_r : 4'd0;
  assign o_mem_addr  = addr_r;
  assign o_mem_wdata = wdata_r;
  assign o_ld_dataM  = ld_data_r;
  assign o_bus_errM  = bus_err_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed cases plus randomized accesses,
// checked against an arithmetic reference model of lane steering and load extension.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst, valid, ren, wen, flush, ack;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rdata;

  logic [31:0] ld, maddr, mwdata, ld_t, maddr_t, mwdata_t;
  logic        stall, mis, berr, req, we, stall_t, mis_t, berr_t, req_t, we_t;
  logic [3:0]  mmask, mmask_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] ld_model, ld_to;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .i_clk(clk), .i_rst(rst), .i_validM(valid), .i_mem_renM(ren), .i_mem_wenM(wen),
    .i_flushM(flush), .i_funct3M(f3), .i_addrM(addr), .i_wdataM(wdata),
    .o_ld_dataM(ld), .o_stallM(stall), .o_misalignM(mis), .o_bus_errM(berr),
    .o_mem_req(req), .o_mem_we(we), .o_mem_addr(maddr), .o_mem_wdata(mwdata),
    .o_mem_bmask(mmask), .i_mem_ack(ack), .i_mem_rdata(rdata)
  );

  mem_stage_lsu #(.MEM_TIMEOUT(4)) dut_to (
    .i_clk(clk), .i_rst(rst), .i_validM(valid), .i_mem_renM(ren), .i_mem_wenM(wen),
    .i_flushM(flush), .i_funct3M(f3), .i_addrM(addr), .i_wdataM(wdata),
    .o_ld_dataM(ld_t), .o_stallM(stall_t), .o_misalignM(mis_t), .o_bus_errM(berr_t),
    .o_mem_req(req_t), .o_mem_we(we_t), .o_mem_addr(maddr_t), .o_mem_wdata(mwdata_t),
    .o_mem_bmask(mmask_t), .i_mem_ack(ack), .i_mem_rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load result: shift the addressed field down, mask, then extend.
  function automatic logic [31:0] model_load(input logic [2:0] fc, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] v;
    if (fc == 3'd0 || fc == 3'd4) begin
      v = (rd >> (8 * off)) & 32'h0000_00FF;
      if (fc == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (fc == 3'd1 || fc == 3'd5) begin
      v = (rd >> (16 * off[1])) & 32'h0000_FFFF;
      if (fc == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    valid = 1'b0; ren = 1'b0; wen = 1'b0; flush = 1'b0; ack = 1'b0;
  endtask

  // One complete access: issue cycle, dly wait cycles then ack, DONE, back to IDLE.
  task automatic do_access(input logic st, input logic [2:0] fc, input logic [31:0] a,
                           input logic [31:0] wd, input int dly, input logic [31:0] rd);
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_mask;
    logic        wordish;
    int          stalls;
    e_addr  = a & 32'hFFFF_FFFC;
    wordish = !(fc == 3'd0 || fc == 3'd4 || fc == 3'd1 || fc == 3'd5);
    if (st && fc == 3'd0) begin
      case (a[1:0])
        2'd0:    e_mask = 4'b0001;
        2'd1:    e_mask = 4'b0010;
        2'd2:    e_mask = 4'b0100;
        default: e_mask = 4'b1000;
      endcase
      e_wd = {24'd0, wd[7:0]} * 32'h0101_0101;
    end else if (st && fc == 3'd1) begin
      e_mask = a[1] ? 4'b1100 : 4'b0011;
      e_wd   = {16'd0, wd[15:0]} * 32'h0001_0001;
    end else begin
      e_mask = 4'b1111;
      e_wd   = wd;
    end
    @(negedge clk);
    valid = 1'b1; ren = !st; wen = st; f3 = fc; addr = a; wdata = wd; ack = 1'b0; flush = 1'b0;
    #1;
    chk("issue_req", req, 1'b0);
    stalls = int'(stall);
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      valid = 1'b0; ren = 1'b0; wen = 1'b0;
      addr  = $urandom; wdata = $urandom; f3 = 3'($urandom);
      flush = (k == 1);
      ack   = (k == dly);
      rdata = (k == dly) ? rd : $urandom;
      #1;
      chk("req_hold", req, 1'b1);
      chk("req_we", we, st);
      chk("req_addr", maddr, e_addr);
      if (st || wordish) chk("req_mask", mmask, e_mask);
      if (st) chk("req_wdata", mwdata, e_wd);
      chk("req_berr", berr, 1'b0);
      stalls += int'(stall);
    end
    @(negedge clk);
    ack = 1'b0; flush = 1'b0;
    if (!st) begin
      ld_model = model_load(fc, a[1:0], rd);
      if (dly < 4) ld_to = ld_model;
    end
    #1;
    chk("done_stall", stall, 1'b0);
    chk("done_req", req, 1'b0);
    chk("done_mask", mmask, 4'd0);
    chk("done_we", we, 1'b0);
    chk("ld_data", ld, ld_model);
    chk("stall_cycles", stalls, dly + 2);
    chk("misalign_quiet", mis, 1'b0);
    @(negedge clk);
    #1;
    chk("idle_stall", stall, 1'b0);
  endtask

  initial begin
    logic        st;
    logic [2:0]  fc;
    logic [31:0] a;
    rst = 1'b1; idle_inputs(); f3 = 3'd0; addr = 32'd0; wdata = 32'd0; rdata = 32'd0;
    ld_model = 32'd0; ld_to = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ld", ld, 32'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_mask", mmask, 4'd0);
    chk("rst_berr", berr, 1'b0);
    chk("rst_mis", mis, 1'b0);
    rst = 1'b0;

    // LB at 0x103, immediate ack: sign-extended 0x80.
    do_access(1'b0, 3'd0, 32'h0000_0103, 32'd0, 0, 32'h80FF_1234);
    chk("lb_value", ld, 32'hFFFF_FF80);
    // SH at 0x102: upper lanes, replicated halfword.
    do_access(1'b1, 3'd1, 32'h0000_0102, 32'h0000_BEEF, 1, 32'd0);
    // LW with ack in the fifth REQ cycle (dut_to abandons it).
    do_access(1'b0, 3'd2, 32'h0000_0040, 32'd0, 4, 32'hCAFE_F00D);

    // Timeout on the MEM_TIMEOUT=4 instance.
    @(negedge clk);
    valid = 1'b1; ren = 1'b1; wen = 1'b0; f3 = 3'd2; addr = 32'h0000_0200; ack = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk("to_req", req_t, 1'b1);
      chk("to_berr_low", berr_t, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("to_dropped", req_t, 1'b0);
    chk("to_berr_pulse", berr_t, 1'b1);
    chk("to_stall", stall_t, 1'b0);
    chk("to_ld_kept", ld_t, ld_to);
    @(negedge clk);
    #1;
    chk("to_berr_single", berr_t, 1'b0);
    chk("long_wait_req", req, 1'b1);
    @(negedge clk);
    ack = 1'b1; rdata = 32'h1357_9BDF;
    @(negedge clk);
    ack = 1'b0;
    ld_model = 32'h1357_9BDF;
    #1;
    chk("long_wait_ld", ld, ld_model);
    chk("ack_ignored_idle", ld_t, ld_to);
    @(negedge clk);

    // Reset asserted mid-REQ, then a normal load.
    @(negedge clk);
    valid = 1'b1; ren = 1'b1; f3 = 3'd2; addr = 32'h0000_0300;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mid_req", req, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", req, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_ld", ld, 32'd0);
    chk("rst_mid_req_t", req_t, 1'b0);
    ld_model = 32'd0; ld_to = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    do_access(1'b0, 3'd5, 32'h0000_0306, 32'd0, 1, 32'h8001_7FFF);

    // LW at 0x102.
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    valid = 1'b1; ren = 1'b1; f3 = 3'd2; addr = 32'h0000_0102;
    #1;
    chk("mis_stall", stall, 1'b0);
    chk("mis_noreq", req, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mis_pulse", mis, 1'b1);
    chk("mis_noreq2", req, 1'b0);
    @(negedge clk);
    #1;
    chk("mis_single", mis, 1'b0);
`else
    do_access(1'b0, 3'd2, 32'h0000_0102, 32'd0, 0, 32'h0BAD_F00D);
`endif

    // Randomized accesses.
    for (int n = 0; n < 24; n++) begin
      st = 1'($urandom);
      fc = st ? 3'($urandom_range(2, 0)) : 3'($urandom_range(7, 0));
      a  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      if (fc[1:0] == 2'b01) a[0] = 1'b0;
      else if (fc[1]) a[1:0] = 2'b00;
`endif
      do_access(st, fc, a, $urandom, int'($urandom_range(3, 0)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
